dte_cra_diag: RTL and testbench

Diagnostic-side initiator for the CRA diagnostic function group. Accepts command requests from the DTE/console logic, drives the `DIAG LOAD FUNC 05x` / `DIAG READ FUNC 14x` strobes, the `DIAG[4:6]` selector, and EBUS data. It loads the 11-bit CRA diagnostic dispatch address in two 6-bit halves, or reads back CRADR, SBR_RET or dispatch/stack status as two 6-bit EBUS samples assembled into one 12-bit response. It sits between the DTE command path and the EBUS diagnostic lines that the CRA decodes.

---
 rtl/dte_cra_diag_pkg.sv | 62 ++++++
 rtl/dte_cra_diag_xfer.sv | 90 +++++++++
 rtl/dte_cra_diag.sv | 128 ++++++++++++
 tb/tb_dte_cra_diag.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/dte_cra_diag_pkg.sv
// dte_cra_diag_pkg
// Types and constants shared by the CRA diagnostic initiator and its
// transfer sequencer: the command opcode enum, the DIAG[4:6] function
// selector codes, the FSM state encodings and the selector lookup that maps
// (opcode, half) to a DIAG[4:6] code.
package dte_cra_diag_pkg;

    typedef enum logic [1:0] {
        OP_LOAD_ADR     = 2'd0,
        OP_READ_CRADR   = 2'd1,
        OP_READ_SBR_RET = 2'd2,
        OP_READ_STATUS  = 2'd3
    } tDiagOp;

    // DIAG[4:6] selectors for the load functions (05x).
    localparam logic [2:0] FUNC_051 = 3'b001;
    localparam logic [2:0] FUNC_052 = 3'b010;

    // DIAG[4:6] selectors for the read functions (14x).
    localparam logic [2:0] RD_STATUS0    = 3'b000;
    localparam logic [2:0] RD_STATUS1    = 3'b001;
    localparam logic [2:0] RD_SBR_RET_LO = 3'b010;
    localparam logic [2:0] RD_SBR_RET_HI = 3'b011;
    localparam logic [2:0] RD_CRADR_LO   = 3'b100;
    localparam logic [2:0] RD_CRADR_HI   = 3'b101;
    localparam logic [2:0] RD_SPARE6     = 3'b110;
    localparam logic [2:0] RD_SPARE7     = 3'b111;

    // Top-level command sequencer states.
    typedef enum logic [1:0] {
        T_IDLE,
        T_XFER,
        T_RSP
    } top_state_e;

    // Phases of a single 6-bit EBUS transfer.
    typedef enum logic [2:0] {
        PH_IDLE,
        PH_W_SETUP,
        PH_W_STROBE,
        PH_W_HOLD,
        PH_R_DRIVE,
        PH_R_SETTLE,
        PH_R_SAMPLE
    } phase_e;

    // Half 0 carries the high-order six bits of the result, so reads select
    // the "HI" function first.
    function automatic logic [2:0] diag_select(input tDiagOp op, input logic half);
        logic [2:0] sel;
        sel = 3'b000;
        case (op)
            OP_LOAD_ADR:     sel = half ? FUNC_051      : FUNC_052;
            OP_READ_CRADR:   sel = half ? RD_CRADR_LO   : RD_CRADR_HI;
            OP_READ_SBR_RET: sel = half ? RD_SBR_RET_LO : RD_SBR_RET_HI;
            OP_READ_STATUS:  sel = half ? RD_STATUS1    : RD_STATUS0;
            default:         sel = 3'b000;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/dte_cra_diag_xfer.sv
// diag_xfer
// Sequences one 6-bit EBUS transfer, either a load (setup / strobe / hold)
// or a read (drive / optional settle / sample). A start seen in the last
// phase chains straight into the next transfer with no idle gap.
// Ports:
//   clk, RESET      clock and synchronous active-high reset
//   start_i         begin a transfer (honoured in PH_IDLE or the last phase)
//   write_i         direction for the transfer being started (1 = load)
//   done_o          high during the last phase of a transfer
//   load_strobe_o   DIAG LOAD FUNC 05x strobe (W_STROBE only)
//   read_en_o       DIAG READ FUNC 14x enable (all read phases)
//   driving_o       this block drives EBUS (all write phases)
//   active_o        any transfer phase in progress
// Build option: DTE_CRA_DIAG_SETTLE_EN adds the R_SETTLE phase of SETTLE cycles.
module diag_xfer
    import dte_cra_diag_pkg::*;
`ifdef DTE_CRA_DIAG_SETTLE_EN
#(
    parameter int unsigned SETTLE = 2
)
`endif
(
    input  logic clk,
    input  logic RESET,
    input  logic start_i,
    input  logic write_i,
    output logic done_o,
    output logic load_strobe_o,
    output logic read_en_o,
    output logic driving_o,
    output logic active_o
);

    phase_e phase_q, phase_d;
    phase_e first_phase;

`ifdef DTE_CRA_DIAG_SETTLE_EN
    logic [3:0] cnt_q;
`endif

    assign first_phase = write_i ? PH_W_SETUP : PH_R_DRIVE;

    always_comb begin
        phase_d = phase_q;
        case (phase_q)
            PH_IDLE:     if (start_i) phase_d = first_phase;
            PH_W_SETUP:  phase_d = PH_W_STROBE;
            PH_W_STROBE: phase_d = PH_W_HOLD;
            PH_W_HOLD:   phase_d = start_i ? first_phase : PH_IDLE;
`ifdef DTE_CRA_DIAG_SETTLE_EN
            PH_R_DRIVE:  phase_d = PH_R_SETTLE;
            PH_R_SETTLE: if (cnt_q == 4'd1) phase_d = PH_R_SAMPLE;
`else
            PH_R_DRIVE:  phase_d = PH_R_SAMPLE;
`endif
            PH_R_SAMPLE: phase_d = start_i ? first_phase : PH_IDLE;
            default:     phase_d = PH_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            phase_q <= PH_IDLE;
        end else begin
            phase_q <= phase_d;
        end
    end

`ifdef DTE_CRA_DIAG_SETTLE_EN
    // Loaded while in R_DRIVE so it holds SETTLE on the first settle cycle.
    always_ff @(posedge clk) begin
        if (RESET) begin
            cnt_q <= 4'd0;
        end else if (phase_q == PH_R_DRIVE) begin
            cnt_q <= 4'(SETTLE);
        end else if (phase_q == PH_R_SETTLE) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end
`endif

    assign load_strobe_o = (phase_q == PH_W_STROBE);
    assign driving_o     = (phase_q == PH_W_SETUP) || (phase_q == PH_W_STROBE) ||
                           (phase_q == PH_W_HOLD);
    assign read_en_o     = (phase_q == PH_R_DRIVE) || (phase_q == PH_R_SETTLE) ||
                           (phase_q == PH_R_SAMPLE);
    assign done_o        = (phase_q == PH_W_HOLD) || (phase_q == PH_R_SAMPLE);
    assign active_o      = driving_o || read_en_o;

endmodule

// File: rtl/dte_cra_diag.sv
// dte_cra_diag
// Diagnostic-side initiator for the CRA diagnostic function group. Accepts
// a command, runs two 6-bit EBUS transfers (load of the 11-bit dispatch
// address, or read-back of CRADR / SBR_RET / status) and presents the
// assembled 12-bit result with a valid/ready handshake.
// Ports:
//   clk, RESET                     clock, synchronous active-high reset
//   cmdValid/cmdReady/cmdOp/cmdAdr command request
//   rspValid/rspReady/rspData      response (rspData zero for loads)
//   diagLoadFunc05x, diagReadFunc14x, diag[4:6]   diagnostic strobes/selector
//   ebusOut, ebusDriving, ebusIn   EBUS data path
// Parameter SETTLE (1..15): read settle cycles, used only when the build
// option DTE_CRA_DIAG_SETTLE_EN is defined.
module dte_cra_diag
    import dte_cra_diag_pkg::*;
#(
    parameter int unsigned SETTLE = 2
) (
    input  logic        clk,
    input  logic        RESET,
    input  logic        cmdValid,
    output logic        cmdReady,
    input  logic [1:0]  cmdOp,
    input  logic [0:10] cmdAdr,
    output logic        rspValid,
    input  logic        rspReady,
    output logic [0:11] rspData,
    output logic        diagLoadFunc05x,
    output logic        diagReadFunc14x,
    output logic [4:6]  diag,
    output logic [0:5]  ebusOut,
    output logic        ebusDriving,
    input  logic [0:5]  ebusIn
);

    if (SETTLE < 1 || SETTLE > 15) begin : g_settle_range
        $error("dte_cra_diag: SETTLE must be in 1..15");
    end

    top_state_e  state_q, state_d;
    tDiagOp      op_q;
    logic [0:10] adr_q;
    logic        half_q;
    logic [0:11] rsp_data_q;

    logic accept;
    logic xfer_start;
    logic xfer_write;
    logic xfer_done;
    logic xfer_strobe;
    logic xfer_read_en;
    logic xfer_driving;
    logic xfer_active;
    logic last_done;

    assign accept    = (state_q == T_IDLE) && cmdValid;
    assign last_done = (state_q == T_XFER) && xfer_done;

    // The sequencer must see the start on the accept edge itself so that the
    // first phase follows accept directly; afterwards direction comes from op_q.
    assign xfer_start = accept || (last_done && !half_q);
    assign xfer_write = accept ? (tDiagOp'(cmdOp) == OP_LOAD_ADR) : (op_q == OP_LOAD_ADR);

    diag_xfer
`ifdef DTE_CRA_DIAG_SETTLE_EN
        #(.SETTLE(SETTLE))
`endif
    u_xfer (
        .clk           (clk),
        .RESET         (RESET),
        .start_i       (xfer_start),
        .write_i       (xfer_write),
        .done_o        (xfer_done),
        .load_strobe_o (xfer_strobe),
        .read_en_o     (xfer_read_en),
        .driving_o     (xfer_driving),
        .active_o      (xfer_active)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            T_IDLE:  if (cmdValid) state_d = T_XFER;
            T_XFER:  if (xfer_done && half_q) state_d = T_RSP;
            T_RSP:   if (rspReady) state_d = T_IDLE;
            default: state_d = T_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            state_q    <= T_IDLE;
            op_q       <= OP_LOAD_ADR;
            adr_q      <= '0;
            half_q     <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q       <= tDiagOp'(cmdOp);
                adr_q      <= cmdAdr;
                half_q     <= 1'b0;
                rsp_data_q <= '0;
            end else if (last_done) begin
                // half only returns to 0 through a new accept.
                half_q <= 1'b1;
                if (op_q != OP_LOAD_ADR) begin
                    if (half_q) begin
                        rsp_data_q[6:11] <= ebusIn;
                    end else begin
                        rsp_data_q[0:5] <= ebusIn;
                    end
                end
            end
        end
    end

    assign cmdReady        = (state_q == T_IDLE);
    assign rspValid        = (state_q == T_RSP);
    assign rspData         = rsp_data_q;
    assign diagLoadFunc05x = xfer_strobe;
    assign diagReadFunc14x = xfer_read_en;
    assign ebusDriving     = xfer_driving;
    assign diag            = xfer_active ? diag_select(op_q, half_q) : 3'b000;
    assign ebusOut         = !xfer_driving ? 6'd0 :
                             half_q        ? adr_q[5:10] : {1'b0, adr_q[0:4]};

endmodule

// File: tb/tb_dte_cra_diag.sv
module tb_dte_cra_diag;

`ifdef DTE_CRA_DIAG_SETTLE_EN
    localparam int S = 3;
`else
    localparam int S = 0;
`endif
    localparam int HALF = 2 + S;

    logic        clk = 1'b0;
    logic        RESET;
    logic        cmdValid;
    logic        cmdReady;
    logic [1:0]  cmdOp;
    logic [0:10] cmdAdr;
    logic        rspValid;
    logic        rspReady;
    logic [0:11] rspData;
    logic        diagLoadFunc05x;
    logic        diagReadFunc14x;
    logic [4:6]  diag;
    logic [0:5]  ebusOut;
    logic        ebusDriving;
    logic [0:5]  ebusIn;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dte_cra_diag #(.SETTLE(3)) dut (
        .clk             (clk),
        .RESET           (RESET),
        .cmdValid        (cmdValid),
        .cmdReady        (cmdReady),
        .cmdOp           (cmdOp),
        .cmdAdr          (cmdAdr),
        .rspValid        (rspValid),
        .rspReady        (rspReady),
        .rspData         (rspData),
        .diagLoadFunc05x (diagLoadFunc05x),
        .diagReadFunc14x (diagReadFunc14x),
        .diag            (diag),
        .ebusOut         (ebusOut),
        .ebusDriving     (ebusDriving),
        .ebusIn          (ebusIn)
    );

    // CRA model: returns a fixed pattern per read selector while enabled.
    always_comb begin
        ebusIn = 6'o00;
        if (diagReadFunc14x) begin
            case (diag)
                3'b101:  ebusIn = 6'o41;
                3'b100:  ebusIn = 6'o25;
                3'b011:  ebusIn = 6'o63;
                3'b010:  ebusIn = 6'o14;
                3'b000:  ebusIn = 6'o07;
                3'b001:  ebusIn = 6'o70;
                default: ebusIn = 6'o00;
            endcase
        end
    end

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0o expected %0o", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Issues a LOAD_ADR at the current negedge; returns in the RSP cycle (edge 7).
    task automatic do_load(input logic [0:10] adr, input logic [5:0] h0, input logic [5:0] h1);
        cmdValid = 1'b1;
        cmdOp    = 2'd0;
        cmdAdr   = adr;
        check("load cmdReady", cmdReady, 1'b1);
        step();
        cmdValid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            check($sformatf("load c%0d drv", k), ebusDriving, 1'b1);
            check($sformatf("load c%0d rd", k), diagReadFunc14x, 1'b0);
            check($sformatf("load c%0d strobe", k), diagLoadFunc05x, (k == 2 || k == 5));
            check($sformatf("load c%0d diag", k), diag, (k <= 3) ? 3'b010 : 3'b001);
            check($sformatf("load c%0d ebus", k), ebusOut, (k <= 3) ? h0 : h1);
            check($sformatf("load c%0d cmdReady", k), cmdReady, 1'b0);
            step();
        end
        check("load rspValid", rspValid, 1'b1);
        check("load rspData", rspData, 12'o0000);
        check("load rsp drv", ebusDriving, 1'b0);
        check("load rsp diag", diag, 3'b000);
        $display("txn LOAD_ADR adr=%04o rspData=%04o", adr, rspData);
    endtask

    // Issues a read at the current negedge; returns in the RSP cycle.
    task automatic do_read(input logic [1:0] op, input logic [2:0] sel0, input logic [2:0] sel1,
                           input logic [11:0] exp);
        cmdValid = 1'b1;
        cmdOp    = op;
        cmdAdr   = 11'o3777;
        check("read cmdReady", cmdReady, 1'b1);
        step();
        cmdValid = 1'b0;
        for (int k = 1; k <= 2 * HALF; k++) begin
            check($sformatf("read op%0d c%0d rd", op, k), diagReadFunc14x, 1'b1);
            check($sformatf("read op%0d c%0d drv", op, k), ebusDriving, 1'b0);
            check($sformatf("read op%0d c%0d strobe", op, k), diagLoadFunc05x, 1'b0);
            check($sformatf("read op%0d c%0d diag", op, k), diag, (k <= HALF) ? sel0 : sel1);
            check($sformatf("read op%0d c%0d rspValid", op, k), rspValid, 1'b0);
            step();
        end
        check($sformatf("read op%0d rspValid", op), rspValid, 1'b1);
        check($sformatf("read op%0d rspData", op), rspData, exp);
        check($sformatf("read op%0d rsp rd", op), diagReadFunc14x, 1'b0);
        $display("txn READ op=%0d rspData=%04o", op, rspData);
    endtask

    initial begin
        RESET    = 1'b1;
        cmdValid = 1'b1;
        cmdOp    = 2'd0;
        cmdAdr   = 11'o1777;
        rspReady = 1'b0;
        repeat (3) step();
        check("reset cmdReady", cmdReady, 1'b1);
        check("reset rspValid", rspValid, 1'b0);
        check("reset strobe", diagLoadFunc05x, 1'b0);
        check("reset rd", diagReadFunc14x, 1'b0);
        check("reset drv", ebusDriving, 1'b0);
        check("reset diag", diag, 3'b000);
        check("reset ebusOut", ebusOut, 6'o00);
        check("reset rspData", rspData, 12'o0000);
        $display("txn RESET cmdReady=%0b rspValid=%0b", cmdReady, rspValid);
        cmdValid = 1'b0;
        RESET    = 1'b0;
        step();
        rspReady = 1'b1;

        // 11'o1777: bits[0:4]=01111 -> {0,01111}=6'o17; bits[5:10]=6'o77.
        do_load(11'o1777, 6'o17, 6'o77);
        step();
        check("after load idle", cmdReady, 1'b1);
        // 11'o1234: bits[0:4]=01010 -> 6'o12; bits[5:10]=011100 -> 6'o34.
        do_load(11'o1234, 6'o12, 6'o34);
        step();

        do_read(2'd1, 3'b101, 3'b100, 12'o4125);
        step();
        check("after cradr idle", cmdReady, 1'b1);
        do_read(2'd2, 3'b011, 3'b010, 12'o6314);
        step();
        do_read(2'd3, 3'b000, 3'b001, 12'o0770);
        step();

        // Reset during W_STROBE of half 1 (cycle 5).
        cmdValid = 1'b1;
        cmdOp    = 2'd0;
        cmdAdr   = 11'o1234;
        step();
        cmdValid = 1'b0;
        repeat (4) step();
        check("midrst strobe before", diagLoadFunc05x, 1'b1);
        check("midrst diag before", diag, 3'b001);
        RESET = 1'b1;
        step();
        check("midrst strobe", diagLoadFunc05x, 1'b0);
        check("midrst cmdReady", cmdReady, 1'b1);
        check("midrst drv", ebusDriving, 1'b0);
        check("midrst diag", diag, 3'b000);
        check("midrst rspValid", rspValid, 1'b0);
        $display("txn RESET mid-LOAD strobe=%0b cmdReady=%0b", diagLoadFunc05x, cmdReady);
        RESET = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            check($sformatf("midrst quiet%0d rspValid", k), rspValid, 1'b0);
            check($sformatf("midrst quiet%0d cmdReady", k), cmdReady, 1'b1);
        end
        do_read(2'd3, 3'b000, 3'b001, 12'o0770);
        step();

        // Back-pressure with a competing command held during RSP.
        rspReady = 1'b0;
        do_read(2'd1, 3'b101, 3'b100, 12'o4125);
        cmdValid = 1'b1;
        cmdOp    = 2'd3;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("bp%0d rspValid", k), rspValid, 1'b1);
            check($sformatf("bp%0d rspData", k), rspData, 12'o4125);
            check($sformatf("bp%0d cmdReady", k), cmdReady, 1'b0);
            check($sformatf("bp%0d rd", k), diagReadFunc14x, 1'b0);
        end
        rspReady = 1'b1;
        step();
        check("bp release rspValid", rspValid, 1'b0);
        check("bp release cmdReady", cmdReady, 1'b1);
        step();
        cmdValid = 1'b0;
        check("bp next rd", diagReadFunc14x, 1'b1);
        check("bp next diag", diag, 3'b000);
        check("bp next cmdReady", cmdReady, 1'b0);
        repeat (2 * HALF) step();
        check("bp next rspValid", rspValid, 1'b1);
        check("bp next rspData", rspData, 12'o0770);
        $display("txn READ_STATUS after back-pressure rspData=%04o", rspData);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
